// File: rtl/vrf_pkg.sv
// Shared types and constants for the vector register-file read path.
package vrf_pkg;

   localparam int unsigned VRF_DATA_WIDTH = 64;
   localparam int unsigned BEAT_BYTES     = VRF_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      SEW8  = 2'd0,
      SEW16 = 2'd1,
      SEW32 = 2'd2,
      SEW64 = 2'd3
   } sew_e;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_BUSY = 1'b1
   } rd_state_e;

   // 'end' is a keyword, so the group-end marker is called stop.
   typedef struct packed {
      logic                  valid;
      logic                  start;
      logic                  stop;
      logic [BEAT_BYTES-1:0] be;
   } beat_side_t;

endpackage

// File: rtl/vrf_tail_mask.sv
// Per-beat byte enables from the remaining byte count of a group.
module vrf_tail_mask #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned BL_WIDTH   = 18
) (
   input  logic [BL_WIDTH-1:0]     bytes_left,
   input  logic                    whole_reg,
   output logic [DATA_WIDTH/8-1:0] be
);

   // Byte i is live while more than i bytes remain; equals (1<<n)-1 saturated to all-ones.
   always_comb begin
      be = '0;
      for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
         be[i] = whole_reg | (bytes_left > BL_WIDTH'(i));
      end
   end

endmodule

// File: rtl/vrf_read_stage.sv
// Vector register-file read stage: issues reads from the address-generator stream and
// returns a two-stage registered operand-beat stream with aligned markers and tail byte-enables.
module vrf_read_stage
   import vrf_pkg::*;
#(
   parameter int unsigned VLEN       = 16384,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned OFF_WIDTH  = 8,
   parameter int unsigned VL_WIDTH   = $clog2(VLEN) + 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   input  logic [ADDR_WIDTH-1:0]           in_addr,
   input  logic [OFF_WIDTH-1:0]            in_off,
   input  logic                            in_start,
   input  logic                            in_end,
   input  logic [1:0]                      in_sew,
   input  logic [VL_WIDTH-1:0]             in_vl,
   input  logic                            in_whole_reg,
   output logic                            rf_rd_en,
   output logic [ADDR_WIDTH+OFF_WIDTH-1:0] rf_rd_addr,
   input  logic [DATA_WIDTH-1:0]           rf_rd_data,
   output logic                            out_valid,
   output logic [DATA_WIDTH-1:0]           out_data,
   output logic [DATA_WIDTH/8-1:0]         out_be,
   output logic                            out_start,
   output logic                            out_end,
   output logic                            err,
   input  logic                            err_clr
);

   localparam int unsigned BL_WIDTH = VL_WIDTH + 3;
   localparam logic [BL_WIDTH-1:0] BEAT_BL = BL_WIDTH'(DATA_WIDTH / 8);

   rd_state_e               state_q, state_d;
   logic [BL_WIDTH-1:0]     bytes_left_q, bytes_left_d;
   logic                    whole_reg_q, whole_reg_d;
   logic                    err_q, err_d;
   beat_side_t              s1_q, s1_d;
   beat_side_t              s2_q, s2_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;

   sew_e                    sew;
   logic [BL_WIDTH-1:0]     vl_ext;
   logic [BL_WIDTH-1:0]     bytes_init;
   logic [BL_WIDTH-1:0]     bytes_cur;
   logic                    whole_cur;
   logic                    accepted;
   logic                    load;
   logic                    proto_err;
   logic [DATA_WIDTH/8-1:0] be_cur;

   always_comb begin
      sew        = sew_e'(in_sew);
      vl_ext     = BL_WIDTH'(in_vl);
      bytes_init = vl_ext;
      case (sew)
         SEW8:    bytes_init = vl_ext;
         SEW16:   bytes_init = vl_ext << 1;
         SEW32:   bytes_init = vl_ext << 2;
         default: bytes_init = vl_ext << 3;
      endcase

      accepted  = 1'b0;
      proto_err = 1'b0;
      state_d   = state_q;
      case (state_q)
         RD_IDLE: begin
            if (in_valid) begin
               accepted  = in_start;
               proto_err = ~in_start;
            end
         end
         default: begin
            // A start while busy abandons the open group and opens the new one.
            if (in_valid) begin
               accepted  = 1'b1;
               proto_err = in_start;
            end
         end
      endcase
      if (accepted) begin
         state_d = in_end ? RD_IDLE : RD_BUSY;
      end

      // The start beat is masked with the freshly loaded count, not the stale register.
      load      = accepted & in_start;
      bytes_cur = load ? bytes_init : bytes_left_q;
      whole_cur = load ? in_whole_reg : whole_reg_q;

      bytes_left_d = bytes_left_q;
      whole_reg_d  = whole_reg_q;
      if (accepted) begin
         bytes_left_d = (bytes_cur > BEAT_BL) ? (bytes_cur - BEAT_BL) : '0;
         whole_reg_d  = whole_cur;
      end

      err_d = (err_q & ~err_clr) | proto_err;
   end

   vrf_tail_mask #(
      .DATA_WIDTH (DATA_WIDTH),
      .BL_WIDTH   (BL_WIDTH)
   ) u_tail_mask (
      .bytes_left (bytes_cur),
      .whole_reg  (whole_cur),
      .be         (be_cur)
   );

   always_comb begin
      s1_d = '0;
      if (accepted) begin
         s1_d.valid = 1'b1;
         s1_d.start = in_start;
         s1_d.stop  = in_end;
         s1_d.be    = be_cur;
      end
      s2_d   = s1_q;
      data_d = s1_q.valid ? rf_rd_data : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RD_IDLE;
         bytes_left_q <= '0;
         whole_reg_q  <= 1'b0;
         err_q        <= 1'b0;
         s1_q         <= '0;
         s2_q         <= '0;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         bytes_left_q <= bytes_left_d;
         whole_reg_q  <= whole_reg_d;
         err_q        <= err_d;
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         data_q       <= data_d;
      end
   end

   assign rf_rd_en   = accepted;
   assign rf_rd_addr = {in_addr, in_off};
   assign out_valid  = s2_q.valid;
   assign out_data   = data_q;
   assign out_be     = s2_q.be;
   assign out_start  = s2_q.start;
   assign out_end    = s2_q.stop;
   assign err        = err_q;

endmodule

// File: tb/tb_vrf_read_stage.sv
// Scoreboard bench for vrf_read_stage: directed groups push expected beats, a forked monitor checks them.
module tb_vrf_read_stage;
   import vrf_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [4:0]  in_addr;
   logic [7:0]  in_off;
   logic        in_start;
   logic        in_end;
   logic [1:0]  in_sew;
   logic [14:0] in_vl;
   logic        in_whole_reg;
   logic        rf_rd_en;
   logic [12:0] rf_rd_addr;
   logic [63:0] rf_rd_data;
   logic        out_valid;
   logic [63:0] out_data;
   logic [7:0]  out_be;
   logic        out_start;
   logic        out_end;
   logic        err;
   logic        err_clr;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  be;
      logic        st;
      logic        en;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   vrf_read_stage #(
      .VLEN       (16384),
      .DATA_WIDTH (64),
      .ADDR_WIDTH (5),
      .OFF_WIDTH  (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_addr      (in_addr),
      .in_off       (in_off),
      .in_start     (in_start),
      .in_end       (in_end),
      .in_sew       (in_sew),
      .in_vl        (in_vl),
      .in_whole_reg (in_whole_reg),
      .rf_rd_en     (rf_rd_en),
      .rf_rd_addr   (rf_rd_addr),
      .rf_rd_data   (rf_rd_data),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_be       (out_be),
      .out_start    (out_start),
      .out_end      (out_end),
      .err          (err),
      .err_clr      (err_clr)
   );

   function automatic logic [63:0] data_of(input logic [12:0] a);
      return {3'b001, a, 3'b010, a, 3'b100, a, 3'b111, a};
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Register-file model: synchronous read, data one cycle after the strobe.
   always @(posedge clk) begin
      rf_rd_data <= rf_rd_en ? data_of(rf_rd_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic beat(input logic st, input logic en, input logic [4:0] a, input logic [7:0] o,
                       input logic [1:0] sew, input logic [14:0] vl, input logic wr,
                       input logic exp_rd, input logic [7:0] exp_be, input logic clr = 1'b0);
      in_valid     = 1'b1;
      in_start     = st;
      in_end       = en;
      in_addr      = a;
      in_off       = o;
      in_sew       = sew;
      in_vl        = vl;
      in_whole_reg = wr;
      err_clr      = clr;
      #1;
      chk("rd_en", rf_rd_en, exp_rd);
      if (exp_rd) begin
         chk("rd_addr", rf_rd_addr, {a, o});
         sb.push_back('{data_of({a, o}), exp_be, st, en, cyc + 2});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic clr = 1'b0);
      in_valid     = 1'b0;
      in_start     = 1'b0;
      in_end       = 1'b0;
      in_whole_reg = 1'b0;
      err_clr      = clr;
      repeat (n) @(posedge clk);
      #1;
      err_clr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      in_addr      = '0;
      in_off       = '0;
      in_start     = 1'b0;
      in_end       = 1'b0;
      in_sew       = '0;
      in_vl        = '0;
      in_whole_reg = 1'b0;
      err_clr      = 1'b0;

      fork
         forever begin : monitor
            exp_t e;
            @(negedge clk);
            if (out_valid === 1'b1) begin
               if (sb.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_beat: got beat data=%h be=%h, required no beat (cycle %0d)",
                           out_data, out_be, cyc);
               end else begin
                  e = sb.pop_front();
                  chk("out_cycle", cyc, e.cyc);
                  chk("out_data", out_data, e.data);
                  chk("out_be", out_be, e.be);
                  chk("out_start", out_start, e.st);
                  chk("out_end", out_end, e.en);
               end
            end
         end
      join_none

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 64'h0);
      chk("rst_out_be", out_be, 8'h00);
      chk("rst_out_start", out_start, 1'b0);
      chk("rst_out_end", out_end, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_rd_en", rf_rd_en, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // sew=16b, vl=10 -> 20 bytes: FF, FF, 0F; junk sew/vl/whole_reg on non-start beats
      beat(1, 0, 5'd3, 8'd0, 2'd1, 15'd10,     1'b0, 1, 8'hFF);
      beat(0, 0, 5'd3, 8'd1, 2'd3, 15'h7FFF,   1'b1, 1, 8'hFF);
      beat(0, 1, 5'd3, 8'd2, 2'd3, 15'h7FFF,   1'b1, 1, 8'h0F);
      idle(3);

      // Single-beat group: sew=8b, vl=3 -> 07, FSM stays idle
      beat(1, 1, 5'd4, 8'd5, 2'd0, 15'd3,      1'b0, 1, 8'h07);
      chk("fsm_idle_single", dut.state_q, RD_IDLE);
      idle(3);

      // Back-to-back: sew=32b vl=3 (12B: FF,0F), then sew=64b vl=1 (8B: FF,00,00)
      beat(1, 0, 5'd5, 8'd0, 2'd2, 15'd3,      1'b0, 1, 8'hFF);
      beat(0, 1, 5'd5, 8'd1, 2'd0, 15'h7FFF,   1'b1, 1, 8'h0F);
      beat(1, 0, 5'd6, 8'd0, 2'd3, 15'd1,      1'b0, 1, 8'hFF);
      beat(0, 0, 5'd6, 8'd1, 2'd0, 15'h7FFF,   1'b0, 1, 8'h00);
      beat(0, 1, 5'd6, 8'd2, 2'd0, 15'h7FFF,   1'b0, 1, 8'h00);
      idle(3);

      // whole_reg=1, vl=0: all FF (whole_reg only driven on the start beat)
      beat(1, 0, 5'd8, 8'd0, 2'd0, 15'd0,      1'b1, 1, 8'hFF);
      beat(0, 0, 5'd8, 8'd1, 2'd0, 15'd0,      1'b0, 1, 8'hFF);
      beat(0, 0, 5'd8, 8'd2, 2'd0, 15'd0,      1'b0, 1, 8'hFF);
      beat(0, 1, 5'd8, 8'd3, 2'd0, 15'd0,      1'b0, 1, 8'hFF);
      idle(2);
      // whole_reg=0, vl=0: all 00, markers intact; junk whole_reg/vl afterwards
      beat(1, 0, 5'd8, 8'd4, 2'd0, 15'd0,      1'b0, 1, 8'h00);
      beat(0, 0, 5'd8, 8'd5, 2'd3, 15'h7FFF,   1'b1, 1, 8'h00);
      beat(0, 0, 5'd8, 8'd6, 2'd3, 15'h7FFF,   1'b1, 1, 8'h00);
      beat(0, 1, 5'd8, 8'd7, 2'd3, 15'h7FFF,   1'b1, 1, 8'h00);
      idle(3);

      // Beat without start while idle: dropped, err next cycle; err_clr; set wins over clear
      chk("err_before_violation", err, 1'b0);
      beat(0, 0, 5'd2, 8'd0, 2'd0, 15'd4,      1'b0, 0, 8'h00);
      chk("err_set_idle_nostart", err, 1'b1);
      idle(1, 1'b1);
      chk("err_cleared", err, 1'b0);
      beat(0, 1, 5'd2, 8'd1, 2'd0, 15'd4,      1'b0, 0, 8'h00, 1'b1);
      chk("err_set_wins_over_clr", err, 1'b1);
      idle(1, 1'b1);
      chk("err_cleared_again", err, 1'b0);
      idle(2);

      // Start while busy: old group (16B) abandoned, new group vl=5 -> 1F, 00
      beat(1, 0, 5'd7, 8'd0, 2'd0, 15'd16,     1'b0, 1, 8'hFF);
      beat(0, 0, 5'd7, 8'd1, 2'd0, 15'h7FFF,   1'b1, 1, 8'hFF);
      beat(1, 0, 5'd10, 8'd0, 2'd0, 15'd5,     1'b0, 1, 8'h1F);
      chk("err_set_busy_start", err, 1'b1);
      beat(0, 1, 5'd10, 8'd1, 2'd3, 15'h7FFF,  1'b1, 1, 8'h00);
      idle(3);

      // Asynchronous reset mid-group: outputs clear at once, no residual beats
      beat(1, 0, 5'd9, 8'd0, 2'd0, 15'd40,     1'b0, 1, 8'hFF);
      beat(0, 0, 5'd9, 8'd1, 2'd0, 15'd0,      1'b0, 1, 8'hFF);
      in_valid = 1'b0;
      in_start = 1'b0;
      in_end   = 1'b0;
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("async_rst_out_valid", out_valid, 1'b0);
      chk("async_rst_out_data", out_data, 64'h0);
      chk("async_rst_out_be", out_be, 8'h00);
      chk("async_rst_out_start", out_start, 1'b0);
      chk("async_rst_out_end", out_end, 1'b0);
      chk("async_rst_err", err, 1'b0);
      chk("async_rst_fsm", dut.state_q, RD_IDLE);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      // Clean group after reset: sew=16b vl=2 -> 0F
      beat(1, 1, 5'd1, 8'd0, 2'd1, 15'd2,      1'b0, 1, 8'h0F);
      idle(4);

      for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d beats still pending, required 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vrf_read_stage.md
Name: vrf_read_stage

Overview:
- Sits directly downstream of the vector address generator.
- Consumes its per-cycle stream of register address, offset and start/end markers, and issues synchronous reads to the vector register file.
- Realigns the start/end markers with the returned data and generates per-beat tail byte-enables from vl and sew.
- Output is a registered, fully aligned operand-beat stream for the execution lanes. The block has no backpressure, because the address generator cannot stall.

Parameters:
- VLEN, 16384, vector register length in bits.
- DATA_WIDTH, 64, beat width in bits; must be a power of two and at least 8.
- ADDR_WIDTH, 5, vector register address width.
- OFF_WIDTH, 8, beat-offset width within one register.
- VL_WIDTH, $clog2(VLEN)+1, vl field width in elements.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low
- in_valid  in  1  beat present; driven from the generator's ~idle
- in_addr  in  ADDR_WIDTH  register address of the beat
- in_off  in  OFF_WIDTH  beat offset within the register
- in_start  in  1  first beat of a group
- in_end  in  1  last beat of a group
- in_sew  in  2  element width code: 0=8b, 1=16b, 2=32b, 3=64b; sampled on in_start
- in_vl  in  VL_WIDTH  active element count; sampled on in_start
- in_whole_reg  in  1  whole-register access, all bytes enabled; sampled on in_start
- rf_rd_en  out  1  register-file read strobe
- rf_rd_addr  out  ADDR_WIDTH+OFF_WIDTH  read address {in_addr,in_off}
- rf_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after rf_rd_en
- out_valid  out  1  operand beat valid
- out_data  out  DATA_WIDTH  operand data
- out_be  out  DATA_WIDTH/8  byte enables; bit i covers bits 8i+7:8i
- out_start  out  1  first beat of group
- out_end  out  1  last beat of group
- err  out  1  sticky protocol-error flag
- err_clr  in  1  synchronous clear for err

Behaviour:
- Reset (async assert, synchronous deassert by the user): all outputs are 0, FSM is IDLE, bytes_left is 0, and the pipe is empty.
- Read issue (combinational): rf_rd_en = in_valid & accepted, where accepted is defined by the FSM rules below. rf_rd_addr = {in_addr,in_off}, driven in the same cycle.
- Pipeline:
  - Stage 1 registers the sideband: valid, start, end, be.
  - Stage 2 registers rf_rd_data together with the stage-1 sideband.
  - A beat accepted in cycle t appears on out_* in cycle t+2.
  - Sustains 1 beat per cycle with no bubbles, including back-to-back groups.
- FSM, two states:
  - IDLE -> BUSY on accepted in_start & ~in_end.
  - IDLE stays IDLE on in_start & in_end (single-beat group).
  - BUSY -> IDLE on accepted in_end.
- Protocol errors (err is set the cycle after the violation and stays set until err_clr):
  - In IDLE, in_valid & ~in_start: beat dropped, no read issued, err set.
  - In BUSY, in_start: current group abandoned without an out_end; new group begins and its beat is accepted; err set.
- Byte accounting:
  - On accepted in_start, bytes_left := in_vl << in_sew, using width VL_WIDTH+3.
  - After each accepted beat, bytes_left := sat0(bytes_left - DATA_WIDTH/8).
  - The start beat uses the freshly loaded value, not the stale register.
- Tail mask:
  - be = all-ones if whole_reg or bytes_left >= DATA_WIDTH/8.
  - Otherwise be = (1<<bytes_left)-1.
  - vl=0 gives be=0 on every beat; beats still flow and markers are preserved.
- Beats remaining after bytes_left reaches 0 carry be=0; the group length is always set by in_end, never by vl.
- err_clr and a new error in the same cycle: the set wins.
- Reset mid-group: pipe contents are discarded and no out_end is produced.

Decomposition:
- Package vrf_pkg holds:
  - BEAT_BYTES = DATA_WIDTH/8.
  - sew_e enum (SEW8, SEW16, SEW32, SEW64).
  - rd_state_e enum (RD_IDLE, RD_BUSY).
  - A beat_side_t struct {valid,start,end,be}.
- One sub-module: vrf_tail_mask, combinational, mapping (bytes_left, whole_reg) to be. It is reused later by the write-back stage.

Test Plan:
- DATA_WIDTH=64, sew=1, vl=10, 3-beat group (start on beat 0, end on beat 2): rf_rd_addr follows {addr,off} in the same cycle; out_be = FF,FF,0F at t+2..t+4; out_start on the first output beat, out_end on the last.
- Single beat with start and end together, sew=0, vl=3: one output beat, be=07, start=end=1, FSM remains IDLE.
- Two groups back-to-back with no gap (second start immediately after the first end): 2 cycles later the output is continuous, markers are correct, and bytes_left reloads for group 2 with no leakage from group 1.
- whole_reg=1 with vl=0 over 4 beats: all be=FF. Repeat with whole_reg=0 and vl=0: all be=00, beats and markers are still present.
- in_valid without in_start in IDLE: no rf_rd_en, no output beat, err=1 next cycle. Then err_clr: err=0.
- in_start mid-group: the old group ends without out_end, the new group streams correctly, and err=1. Separately, assert rst_n low mid-group: outputs are 0 immediately (async), with no residual beats after release.
